// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the line-buffer chain: primes KERNEL_HEIGHT-1 rows, then paces pixels on m_ready.
// Optional framing check against s_last is enabled by defining LB_CTRL_FRAME_CHECK_EN.
module line_buffer_ctrl #(
  parameter int IMG_WIDTH     = 854,
  parameter int IMG_HEIGHT    = 480,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_last,
  input  logic          m_ready,
  output logic          lb_push,
  output logic          lb_r_ready,
  output logic          win_valid,
  output logic          win_border,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] PRIME_ROW  = RW'(KERNEL_HEIGHT - 2);
  localparam logic [CW-1:0] BORDER_COL = CW'(KERNEL_WIDTH - 1);

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;
  logic          at_line_end;
  logic          at_frame_end;

  // Backpressure is ignored while priming: the FIFOs must fill before any window exists.
  assign s_ready      = (state == PRIME) || ((state == RUN) && m_ready);
  assign accept       = s_valid && s_ready;
  assign lb_push      = accept;
  assign lb_r_ready   = s_ready;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);
  assign at_line_end  = (col == COL_LAST);
  assign at_frame_end = at_line_end && (row == ROW_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   if (accept && at_line_end && (row == PRIME_ROW)) state_nxt = RUN;
      RUN:     if (accept && at_frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if ((state == IDLE) && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (at_line_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // One-cycle window strobe aligned with the BRAM read latency of the FIFO chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_border <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= accept && (state == RUN);
      win_border <= accept && (state == RUN) && (col < BORDER_COL);
      if (accept && (state == RUN)) begin
        win_row <= row;
        win_col <= col;
      end
    end
  end

`ifdef LB_CTRL_FRAME_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err <= 1'b0;
    else if (accept && (s_last != at_frame_end)) err <= 1'b1;
  end
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl on an 8x4 frame with a 3x3 kernel.
module tb_line_buffer_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int KW = 3;
  localparam int KH = 3;
  localparam int PRIME_N = (KH - 1) * W;
  localparam int TOTAL_N = W * H;
`ifdef LB_CTRL_FRAME_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  typedef struct {
    int row;
    int col;
    bit border;
  } win_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, s_valid, s_last, m_ready;
  logic       s_ready, lb_push, lb_r_ready;
  logic       win_valid, win_border, busy, frame_done, err;
  logic [1:0] win_row;
  logic [2:0] win_col;

  int   errors = 0;
  int   checks = 0;
  win_t exp_q[$];
  int   phase;      // 0 idle, 1 active, 2 done
  int   n;          // accepts so far in this frame
  bit   exp_err, exp_win;
  int   cyc, fd_cyc, fd_count, win_cnt, border_cnt;

  line_buffer_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_WIDTH(KW), .KERNEL_HEIGHT(KH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .m_ready(m_ready), .lb_push(lb_push), .lb_r_ready(lb_r_ready),
    .win_valid(win_valid), .win_border(win_border), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".s_ready"},    s_ready,    0);
    check({tag, ".lb_push"},    lb_push,    0);
    check({tag, ".lb_r_ready"}, lb_r_ready, 0);
    check({tag, ".win_valid"},  win_valid,  0);
    check({tag, ".win_border"}, win_border, 0);
    check({tag, ".win_row"},    win_row,    0);
    check({tag, ".win_col"},    win_col,    0);
    check({tag, ".busy"},       busy,       0);
    check({tag, ".frame_done"}, frame_done, 0);
    check({tag, ".err"},        err,        0);
  endtask

  task automatic model_clear();
    phase = 0; n = 0; exp_err = 0; exp_win = 0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, check combinational handshake, then check registered outputs after the edge.
  task automatic step(input logic sv, input logic mr, input logic st, input logic sl);
    bit   exp_rdy, acc;
    win_t e;
    @(negedge clk);
    s_valid = sv; m_ready = mr; start = st; s_last = sl;
    #1;
    exp_rdy = (phase == 1) && ((n < PRIME_N) || mr);
    check("s_ready",    s_ready,    exp_rdy);
    check("lb_push",    lb_push,    sv && exp_rdy);
    check("lb_r_ready", lb_r_ready, exp_rdy);
    check("busy",       busy,       phase != 0);
    @(posedge clk);
    acc     = sv && exp_rdy;
    exp_win = 0;
    if (phase == 0) begin
      if (st) begin phase = 1; n = 0; end
    end else if (phase == 1) begin
      if (acc) begin
        if (n >= PRIME_N) begin
          e.row = n / W; e.col = n % W; e.border = (n % W) < (KW - 1);
          exp_q.push_back(e);
          exp_win = 1;
        end
        if (FCHK && (sl != (n == TOTAL_N - 1))) exp_err = 1;
        n++;
        if (n == TOTAL_N) phase = 2;
      end
    end else begin
      phase = 0;
    end
    cyc++;
    #1;
    check("win_valid", win_valid, exp_win);
    if (win_valid) begin
      if (exp_q.size() == 0) check("win_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("win_row",    win_row,    e.row);
        check("win_col",    win_col,    e.col);
        check("win_border", win_border, e.border);
        win_cnt++;
        if (win_border) border_cnt++;
      end
    end
    check("frame_done", frame_done, phase == 2);
    check("err",        err,        exp_err);
    if (frame_done) begin fd_count++; fd_cyc = cyc; end
  endtask

  task automatic clean_frame(input string tag);
    fd_count = 0; fd_cyc = 0; win_cnt = 0; border_cnt = 0;
    cyc = 1;
    step(0, 1, 1, 0);
    for (int i = 0; i < TOTAL_N; i++) step(1, 1, 0, i == TOTAL_N - 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check({tag, ".fd_cycle"},   fd_cyc,       34);
    check({tag, ".fd_count"},   fd_count,     1);
    check({tag, ".windows"},    win_cnt,      TOTAL_N - PRIME_N);
    check({tag, ".borders"},    border_cnt,   (H - KH + 1) * (KW - 1));
    check({tag, ".queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1; start = 0; s_valid = 0; s_last = 0; m_ready = 0;
    model_clear();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;

    clean_frame("frame1");

    // Stalled priming, an s_valid gap, RUN stall at (2,4), stray start at (3,2), early s_last at pixel 20.
    begin
      int  stall = 0;
      bit  gap_done = 0, st_done = 0;
      bit  sv, mr, st, sl;
      fd_count = 0; win_cnt = 0;
      step(0, 0, 1, 0);
      for (int k = 0; k < 200 && phase == 1; k++) begin
        sv = 1; mr = 1; st = 0;
        if (n < PRIME_N) mr = 0;
        if (n == 5 && !gap_done) begin sv = 0; gap_done = 1; end
        if (n == 20 && stall < 5) begin mr = 0; stall++; end
        if (n == 26 && !st_done) begin st = 1; st_done = 1; end
        sl = (n == 20) || (n == TOTAL_N - 1);
        step(sv, mr, st, sl);
      end
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("frame2.fd_count",   fd_count,     1);
      check("frame2.windows",    win_cnt,      TOTAL_N - PRIME_N);
      check("frame2.queue_left", exp_q.size(), 0);
      check("frame2.err_held",   err,          FCHK);
    end

    // Asynchronous reset mid-frame at (3,3), then a full clean frame.
    step(0, 1, 1, 0);
    for (int k = 0; k < 100 && n < 27; k++) step(1, 1, 0, 0);
    @(negedge clk);
    s_valid = 1; m_ready = 1;
    #2 rst = 1;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    @(negedge clk);
    s_valid = 0;
    rst = 0;
    clean_frame("frame4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Frame-level sequencer for the line-buffer datapath. It sits between the pixel source and the chain of line-buffer FIFOs and windowing logic, and paces pixel acceptance. It primes the first KERNEL_HEIGHT-1 rows, then gates the stream on downstream backpressure. It also tracks row and column position and emits per-pixel window strobes with border classification and end-of-frame status.

## Interface
- IMG_WIDTH, 854: pixels per line; equals the line-buffer FIFO depth.
- IMG_HEIGHT, 480: lines per frame.
- KERNEL_WIDTH, 3: window width, ≥2.
- KERNEL_HEIGHT, 3: window height, ≥2; KERNEL_HEIGHT-1 FIFOs in chain.
- CW = $clog2(IMG_WIDTH), RW = $clog2(IMG_HEIGHT) (derived).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  upstream pixel accepted when s_valid&&s_ready.
- s_last  in  1  upstream end-of-frame marker (see Configuration).
- m_ready  in  1  window consumer can take another window.
- lb_push  out  1  drives FIFO-chain w_valid; = s_valid&&s_ready.
- lb_r_ready  out  1  drives FIFO-chain r_ready; = s_ready.
- win_valid  out  1  registered one-cycle window strobe.
- win_border  out  1  qualifies win_valid: window wraps left edge, discard.
- win_row  out  RW  row of newest pixel in the window.
- win_col  out  CW  column of newest pixel in the window.
- busy  out  1  high in PRIME/RUN/DONE.
- frame_done  out  1  one-cycle pulse at end of frame.
- err  out  1  sticky framing error.

## Operation
- States: IDLE, PRIME, RUN, DONE.
- IDLE: s_ready=0. start=1 → PRIME next edge. start outside IDLE is ignored.
- PRIME: s_ready=1 regardless of m_ready; FIFOs are filling and produce no output. Leave for RUN on the accept at (row=KERNEL_HEIGHT-2, col=IMG_WIDTH-1), i.e. after (KERNEL_HEIGHT-1)*IMG_WIDTH accepts.
- RUN: s_ready=m_ready, combinationally. Each accept schedules a window strobe. Accept at (IMG_HEIGHT-1, IMG_WIDTH-1) → DONE.
- DONE: one cycle, s_ready=0, frame_done=1 → IDLE.
- Counters: col increments on each accept and wraps IMG_WIDTH-1→0 with row+1. Both clear on entry to PRIME. No other update; they hold while stalled.
- Border: win_border=1 when accepted col < KERNEL_WIDTH-1.
- lb_push and lb_r_ready are combinational; no extra pipeline on the FIFO side.

## Timing
- Reset values: state IDLE, row=col=0, s_ready=0, lb_push=0, lb_r_ready=0, win_valid=0, win_border=0, win_row=0, win_col=0, busy=0, frame_done=0, err=0.
- win_valid latency: win_valid, win_border, win_row and win_col register one cycle after the RUN accept, matching BRAM read latency.
- win_valid is a pulse with no hold. The consumer must capture it. Backpressure acts only by deasserting m_ready, which blocks the next accept in the same cycle.
- frame_done asserts the cycle after the final accept, coincident with the last win_valid.
- Continuous stream: one accept per cycle. Frame takes IMG_WIDTH*IMG_HEIGHT+2 cycles from start: 1 cycle IDLE→PRIME, the accepts, then DONE.
- s_valid=0 in PRIME/RUN: no accept, counters hold, no strobe.
- Reset mid-frame: immediate return to reset values. The FIFOs share rst, so the next start begins at (0,0).

## Configuration
- LB_CTRL_FRAME_CHECK_EN defined:
  - err sets on an accept where s_last=1 and position ≠ (IMG_HEIGHT-1, IMG_WIDTH-1).
  - err also sets on an accept at that final position with s_last=0.
  - err stays set until rst; sequencing is unaffected.
- Undefined: s_last ignored, err tied 0.

## Test plan
Scenarios use IMG_WIDTH=8, IMG_HEIGHT=4, KERNEL_WIDTH=KERNEL_HEIGHT=3.
- Reset → all outputs at reset values. Start, 32 back-to-back pixels, m_ready=1 → PRIME for accepts 1–16, 16 win_valid pulses with win_border on (2,0),(2,1),(3,0),(3,1), frame_done at cycle 34 after start.
- RUN, m_ready=0 for 5 cycles at (2,4) → s_ready=lb_push=0 same cycle, counters hold at (2,4), no win_valid; resume gives win_col=4.
- PRIME with m_ready=0 → s_ready=1, priming completes after 16 accepts.
- start pulsed at (3,2) → ignored, frame ends normally with a single frame_done.
- Macro defined, s_last=1 at pixel 20 → err=1 next cycle, held through frame end; undefined → err=0.
- rst asserted at (3,3) → outputs at reset values without a clock edge; new start runs a full correct frame from (0,0).
